// File: rtl/bin_to_bcd_pipe.sv
// Iterative shift-and-add-3 binary-to-BCD converter with valid/ready handshakes,
// optional two's-complement input and a leading-zero mask for display blanking.
module bin_to_bcd_pipe #(
  parameter int unsigned BIN_W  = 12,
  parameter int unsigned DIGITS = 4,
  parameter int unsigned SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  sign_out,
  output logic [DIGITS-1:0]     lz_mask
);

  localparam int unsigned ACC_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shreg_q, shreg_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sgn_cap_q, sgn_cap_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic               sign_q, sign_d;
  logic [DIGITS-1:0]  lz_q, lz_d;

  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_sh;
  logic [BIN_W-1:0]   shreg_sh;
  logic [DIGITS-1:0]  lz_new;
  logic               zero_run;
  logic               neg_in;
  logic [BIN_W-1:0]   mag;

  // Datapath helpers: add-3 correction, shift, leading-zero scan, magnitude.
  always_comb begin
    acc_adj = acc_q;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (acc_q[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
    end
    {acc_sh, shreg_sh} = {acc_adj, shreg_q} << 1;

    lz_new   = '0;
    zero_run = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_run  = zero_run & (acc_sh[4*i +: 4] == 4'd0);
      lz_new[i] = zero_run;
    end

    neg_in = (SIGNED != 0) && bin_in[BIN_W-1];
    mag    = neg_in ? BIN_W'(~bin_in + BIN_W'(1)) : bin_in;
  end

  // Next-state and register updates.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sgn_cap_d   = sgn_cap_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    bcd_d       = bcd_q;
    sign_d      = sign_q;
    lz_d        = lz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d    = mag;
          acc_d      = '0;
          cnt_d      = CNT_W'(BIN_W);
          sgn_cap_d  = neg_in;
          in_ready_d = 1'b0;
          state_d    = CONV;
        end
      end
      CONV: begin
        acc_d   = acc_sh;
        shreg_d = shreg_sh;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          bcd_d       = acc_sh;
          lz_d        = lz_new;
          sign_d      = sgn_cap_q;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sgn_cap_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bcd_q       <= '0;
      sign_q      <= 1'b0;
      lz_q        <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sgn_cap_q   <= sgn_cap_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      bcd_q       <= bcd_d;
      sign_q      <= sign_d;
      lz_q        <= lz_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bcd_out   = bcd_q;
  assign sign_out  = sign_q;
  assign lz_mask   = lz_q;

endmodule

// File: tb/tb_bin_to_bcd_pipe.sv
// Bench for bin_to_bcd_pipe: three parameterisations (unsigned 12/4, signed 12/4,
// unsigned 16/5) driven from a vector table plus backpressure and reset sequences.
module tb_bin_to_bcd_pipe;

  logic clk;
  logic rst;

  logic        iv   [3];
  logic        ordy [3];
  logic [15:0] bin  [3];

  logic        ir   [3];
  logic        ov   [3];
  logic        sgn  [3];
  logic [19:0] bcd  [3];
  logic [4:0]  lz   [3];

  logic [15:0] bcd0, bcd1;
  logic [19:0] bcd2;
  logic [3:0]  lz0, lz1;
  logic [4:0]  lz2;
  logic        ir0, ir1, ir2, ov0, ov1, ov2, sg0, sg1, sg2;

  bin_to_bcd_pipe #(.BIN_W(12), .DIGITS(4), .SIGNED(0)) u_uns (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .bin_in(bin[0][11:0]),
    .out_valid(ov0), .out_ready(ordy[0]), .bcd_out(bcd0), .sign_out(sg0), .lz_mask(lz0));

  bin_to_bcd_pipe #(.BIN_W(12), .DIGITS(4), .SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .bin_in(bin[1][11:0]),
    .out_valid(ov1), .out_ready(ordy[1]), .bcd_out(bcd1), .sign_out(sg1), .lz_mask(lz1));

  bin_to_bcd_pipe #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u_wide (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .bin_in(bin[2]),
    .out_valid(ov2), .out_ready(ordy[2]), .bcd_out(bcd2), .sign_out(sg2), .lz_mask(lz2));

  assign ir[0] = ir0;  assign ir[1] = ir1;  assign ir[2] = ir2;
  assign ov[0] = ov0;  assign ov[1] = ov1;  assign ov[2] = ov2;
  assign sgn[0] = sg0; assign sgn[1] = sg1; assign sgn[2] = sg2;
  assign bcd[0] = {4'h0, bcd0}; assign bcd[1] = {4'h0, bcd1}; assign bcd[2] = bcd2;
  assign lz[0] = {1'b0, lz0};   assign lz[1] = {1'b0, lz1};   assign lz[2] = lz2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Waits for in_ready, accepts val, returns edges until out_valid.
  task automatic do_conv(input int sel, input logic [15:0] val, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ir[sel] && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!ir[sel]) chk("in_ready_wait", 32'(ir[sel]), 32'd1);
    iv[sel]  = 1'b1;
    bin[sel] = val;
    @(posedge clk);
    #1;
    iv[sel]  = 1'b0;
    bin[sel] = 16'($urandom);
    lat = 0;
    while (!ov[sel] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  typedef struct {
    int          sel;
    logic [15:0] bin;
    logic [19:0] bcd;
    logic        sgn;
    logic [4:0]  lz;
    int          lat;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  initial begin
    int lat;

    vecs[0]  = '{0, 16'd15,    20'h00015, 1'b0, 5'b01100, 12};
    vecs[1]  = '{0, 16'd4095,  20'h04095, 1'b0, 5'b00000, 12};
    vecs[2]  = '{0, 16'd0,     20'h00000, 1'b0, 5'b01110, 12};
    vecs[3]  = '{0, 16'd1234,  20'h01234, 1'b0, 5'b00000, 12};
    vecs[4]  = '{0, 16'd100,   20'h00100, 1'b0, 5'b01000, 12};
    vecs[5]  = '{1, 16'h0800,  20'h02048, 1'b1, 5'b00000, 12};
    vecs[6]  = '{1, 16'h0FFF,  20'h00001, 1'b1, 5'b01110, 12};
    vecs[7]  = '{1, 16'd2047,  20'h02047, 1'b0, 5'b00000, 12};
    vecs[8]  = '{1, 16'd0,     20'h00000, 1'b0, 5'b01110, 12};
    vecs[9]  = '{1, 16'h0ECF,  20'h00305, 1'b1, 5'b01000, 12};
    vecs[10] = '{2, 16'd65535, 20'h65535, 1'b0, 5'b00000, 16};
    vecs[11] = '{2, 16'd7,     20'h00007, 1'b0, 5'b11110, 16};

    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k]   = 1'b0;
      ordy[k] = 1'b1;
      bin[k]  = 16'h0;
    end

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_in_ready[%0d]", k),  32'(ir[k]),  32'd1);
      chk($sformatf("reset_out_valid[%0d]", k), 32'(ov[k]),  32'd0);
      chk($sformatf("reset_bcd[%0d]", k),       32'(bcd[k]), 32'd0);
      chk($sformatf("reset_lz[%0d]", k),        32'(lz[k]),  32'd0);
      chk($sformatf("reset_sign[%0d]", k),      32'(sgn[k]), 32'd0);
    end
    rst = 1'b0;

    for (int v = 0; v < NV; v++) begin
      do_conv(vecs[v].sel, vecs[v].bin, lat);
      chk($sformatf("vec%0d_latency", v), 32'(lat),              32'(vecs[v].lat));
      chk($sformatf("vec%0d_bcd", v),     32'(bcd[vecs[v].sel]), 32'(vecs[v].bcd));
      chk($sformatf("vec%0d_sign", v),    32'(sgn[vecs[v].sel]), 32'(vecs[v].sgn));
      chk($sformatf("vec%0d_lz", v),      32'(lz[vecs[v].sel]),  32'(vecs[v].lz));
    end

    // Backpressure: result held, input ignored while out_ready is low.
    ordy[0] = 1'b0;
    do_conv(0, 16'd321, lat);
    chk("bp_latency", 32'(lat), 32'd12);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      iv[0]  = 1'b1;
      bin[0] = 16'd5;
      @(posedge clk);
      #1;
      chk($sformatf("bp_bcd_c%0d", k),       32'(bcd[0]), 32'h0321);
      chk($sformatf("bp_out_valid_c%0d", k), 32'(ov[0]),  32'd1);
      chk($sformatf("bp_in_ready_c%0d", k),  32'(ir[0]),  32'd0);
    end
    @(negedge clk);
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", 32'(ov[0]),  32'd0);
    chk("bp_release_in_ready",  32'(ir[0]),  32'd1);
    chk("bp_release_bcd_held",  32'(bcd[0]), 32'h0321);
    do_conv(0, 16'd999, lat);
    chk("b2b_latency", 32'(lat),    32'd12);
    chk("b2b_bcd",     32'(bcd[0]), 32'h0999);
    chk("b2b_lz",      32'(lz[0]),  32'b1000);

    // Reset in the middle of a conversion.
    @(negedge clk);
    iv[0]  = 1'b1;
    bin[0] = 16'd1234;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(ov[0]),  32'd0);
    chk("rst_in_ready",  32'(ir[0]),  32'd1);
    chk("rst_bcd",       32'(bcd[0]), 32'd0);
    chk("rst_lz",        32'(lz[0]),  32'd0);
    chk("rst_sgn_sign",  32'(sgn[1]), 32'd0);
    chk("rst_sgn_bcd",   32'(bcd[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_conv(0, 16'd1234, lat);
    chk("post_rst_latency", 32'(lat),    32'd12);
    chk("post_rst_bcd",     32'(bcd[0]), 32'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
